// File: rtl/sdr_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sdr_arb_pkg
// Brief   : Shared types and helpers for the sdr_app_arbiter slice.
// Revision: 1.0 - initial release
// ============================================================================
package sdr_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } arb_state_e;

  // Request fields are sized for the default app_* interface widths.
  localparam int c_ARB_AW = 26;
  localparam int c_ARB_BL = 9;

  typedef struct packed {
    logic [c_ARB_AW-1:0] addr;
    logic [c_ARB_BL-1:0] len;
    logic                wr_n;
  } arb_req_t;

  function automatic int ch_idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sdr_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module  : sdr_tag_fifo
// Brief   : Small synchronous FIFO holding channel tags of outstanding bursts.
// Revision: 1.0 - initial release
// ============================================================================
module sdr_tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int c_PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_PW-1:0]  r_wr_ptr;
  logic [c_PW-1:0]  r_rd_ptr;
  logic [c_PW:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (c_PW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop & ~o_empty;
  // A push into a full FIFO is accepted when the head leaves in the same cycle.
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + c_PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_PW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (c_PW+1)'(1);
        2'b01:   r_count <= r_count - (c_PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule
`default_nettype wire

// File: rtl/sdr_app_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : sdr_app_arbiter
// Brief   : N-channel round-robin front end for the sdrc_core app_* port; data
//           phases return in order to their owner through wr/rd tag FIFOs.
//           Define SDR_ARB_PRIO_EN to make channel 0 strict high priority.
// Revision: 1.0 - initial release
// ============================================================================
module sdr_app_arbiter
  import sdr_arb_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int APP_AW    = 26,
  parameter int DW        = 32,
  parameter int BL        = 9,
  parameter int TAG_DEPTH = 4
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH*APP_AW-1:0] ch_req_addr,
  input  logic [NUM_CH*BL-1:0]     ch_req_len,
  input  logic [NUM_CH-1:0]        ch_req_wr_n,
  output logic [NUM_CH-1:0]        ch_req_ack,
  input  logic [NUM_CH*DW-1:0]     ch_wr_data,
  input  logic [NUM_CH*DW/8-1:0]   ch_wr_en_n,
  output logic [NUM_CH-1:0]        ch_wr_next,
  output logic [NUM_CH-1:0]        ch_rd_valid,
  output logic [NUM_CH-1:0]        ch_last_rd,
  output logic [DW-1:0]            ch_rd_data,
  output logic                     app_req,
  output logic [APP_AW-1:0]        app_req_addr,
  output logic [BL-1:0]            app_req_len,
  output logic                     app_req_wr_n,
  input  logic                     app_req_ack,
  output logic [DW-1:0]            app_wr_data,
  output logic [DW/8-1:0]          app_wr_en_n,
  input  logic                     app_wr_next_req,
  input  logic                     app_last_wr,
  input  logic                     app_rd_valid,
  input  logic                     app_last_rd,
  input  logic [DW-1:0]            app_rd_data,
  output logic                     arb_err
);

  localparam int c_IDW = ch_idw(NUM_CH);
  localparam int c_BEW = DW / 8;

  arb_state_e       r_state;
  logic [c_IDW-1:0] r_grant;
  logic [c_IDW-1:0] r_rr_ptr;
  arb_req_t         r_req;
  logic             r_app_req;
  logic             r_err;
  logic [NUM_CH-1:0] w_elig;
  logic             w_any;
  logic [c_IDW-1:0] w_sel;
  logic             w_sel_prio;
  int               w_idx;
  arb_req_t         w_sel_req;
  logic             w_ack;
  logic             w_err_evt;
  logic [c_IDW-1:0] w_wr_head, w_rd_head;
  logic             w_wr_full, w_wr_empty, w_rd_full, w_rd_empty;
`ifdef SDR_ARB_PRIO_EN
  logic             r_prio_win;
`endif

  assign w_ack = (r_state == REQ) & app_req_ack;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++)
      w_elig[i] = ch_req[i] & (ch_req_wr_n[i] ? ~w_rd_full : ~w_wr_full);
  end

  always_comb begin
    w_any      = 1'b0;
    w_sel      = '0;
    w_sel_prio = 1'b0;
    w_idx      = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_idx = int'(r_rr_ptr) + k;
      if (w_idx >= NUM_CH) w_idx = w_idx - NUM_CH;
      if (!w_any && w_elig[w_idx[c_IDW-1:0]]) begin
        w_any = 1'b1;
        w_sel = w_idx[c_IDW-1:0];
      end
    end
`ifdef SDR_ARB_PRIO_EN
    if (w_elig[0]) begin
      w_sel      = '0;
      w_sel_prio = 1'b1;
    end
`endif
  end

  always_comb begin
    w_sel_req = '{addr: '0, len: '0, wr_n: 1'b1};
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_sel == c_IDW'(i)) begin
        w_sel_req.addr = c_ARB_AW'(ch_req_addr[i*APP_AW +: APP_AW]);
        w_sel_req.len  = c_ARB_BL'(ch_req_len[i*BL +: BL]);
        w_sel_req.wr_n = ch_req_wr_n[i];
      end
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_rr_ptr  <= '0;
      r_req     <= '{addr: '0, len: '0, wr_n: 1'b1};
      r_app_req <= 1'b0;
`ifdef SDR_ARB_PRIO_EN
      r_prio_win <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant   <= w_sel;
            r_req     <= w_sel_req;
            r_app_req <= 1'b1;
            r_state   <= REQ;
`ifdef SDR_ARB_PRIO_EN
            r_prio_win <= w_sel_prio;
`endif
          end
        end
        REQ: begin
          if (app_req_ack) begin
            r_app_req <= 1'b0;
            r_state   <= IDLE;
`ifdef SDR_ARB_PRIO_EN
            if (!r_prio_win)
`endif
            r_rr_ptr <= (r_grant == c_IDW'(NUM_CH-1)) ? '0 : r_grant + c_IDW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Stray data-phase strobes and acks outside REQ are dropped but remembered.
  assign w_err_evt = ((app_rd_valid | app_last_rd) & w_rd_empty)
                   | ((app_wr_next_req | app_last_wr) & w_wr_empty)
                   | (app_req_ack & (r_state == IDLE));

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) r_err <= 1'b0;
    else          r_err <= r_err | w_err_evt;
  end

  sdr_tag_fifo #(.WIDTH(c_IDW), .DEPTH(TAG_DEPTH)) u_wr_tags (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .i_push  (w_ack & ~r_req.wr_n),
    .i_data  (r_grant),
    .i_pop   (app_last_wr),
    .o_head  (w_wr_head),
    .o_full  (w_wr_full),
    .o_empty (w_wr_empty)
  );

  sdr_tag_fifo #(.WIDTH(c_IDW), .DEPTH(TAG_DEPTH)) u_rd_tags (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .i_push  (w_ack & r_req.wr_n),
    .i_data  (r_grant),
    .i_pop   (app_last_rd),
    .o_head  (w_rd_head),
    .o_full  (w_rd_full),
    .o_empty (w_rd_empty)
  );

  always_comb begin
    ch_req_ack  = '0;
    ch_wr_next  = '0;
    ch_rd_valid = '0;
    ch_last_rd  = '0;
    app_wr_data = '0;
    app_wr_en_n = '1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_ack && r_grant == c_IDW'(i)) ch_req_ack[i] = 1'b1;
      if (!w_wr_empty && w_wr_head == c_IDW'(i)) begin
        ch_wr_next[i] = app_wr_next_req;
        app_wr_data   = ch_wr_data[i*DW +: DW];
        app_wr_en_n   = ch_wr_en_n[i*c_BEW +: c_BEW];
      end
      if (!w_rd_empty && w_rd_head == c_IDW'(i)) begin
        ch_rd_valid[i] = app_rd_valid;
        ch_last_rd[i]  = app_last_rd;
      end
    end
  end

  assign app_req      = r_app_req;
  assign app_req_addr = APP_AW'(r_req.addr);
  assign app_req_len  = BL'(r_req.len);
  assign app_req_wr_n = r_req.wr_n;
  assign ch_rd_data   = app_rd_data;
  assign arb_err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sdr_app_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_sdr_app_arbiter
// Brief   : Scoreboard bench for sdr_app_arbiter with directed request and
//           data-phase vectors.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sdr_app_arbiter;

  localparam int NUM_CH = 4, APP_AW = 26, DW = 32, BL = 9, TAG_DEPTH = 4;
  localparam int BEW = DW / 8;

  logic                     wb_clk_i = 1'b0;
  logic                     wb_rst_i;
  logic [NUM_CH-1:0]        ch_req;
  logic [NUM_CH*APP_AW-1:0] ch_req_addr;
  logic [NUM_CH*BL-1:0]     ch_req_len;
  logic [NUM_CH-1:0]        ch_req_wr_n;
  logic [NUM_CH-1:0]        ch_req_ack;
  logic [NUM_CH*DW-1:0]     ch_wr_data;
  logic [NUM_CH*BEW-1:0]    ch_wr_en_n;
  logic [NUM_CH-1:0]        ch_wr_next, ch_rd_valid, ch_last_rd;
  logic [DW-1:0]            ch_rd_data;
  logic                     app_req, app_req_wr_n, app_req_ack;
  logic [APP_AW-1:0]        app_req_addr;
  logic [BL-1:0]            app_req_len;
  logic [DW-1:0]            app_wr_data, app_rd_data;
  logic [BEW-1:0]           app_wr_en_n;
  logic                     app_wr_next_req, app_last_wr, app_rd_valid, app_last_rd;
  logic                     arb_err;

  always #5 wb_clk_i = ~wb_clk_i;

  sdr_app_arbiter #(
    .NUM_CH(NUM_CH), .APP_AW(APP_AW), .DW(DW), .BL(BL), .TAG_DEPTH(TAG_DEPTH)
  ) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .ch_req(ch_req), .ch_req_addr(ch_req_addr), .ch_req_len(ch_req_len),
    .ch_req_wr_n(ch_req_wr_n), .ch_req_ack(ch_req_ack),
    .ch_wr_data(ch_wr_data), .ch_wr_en_n(ch_wr_en_n), .ch_wr_next(ch_wr_next),
    .ch_rd_valid(ch_rd_valid), .ch_last_rd(ch_last_rd), .ch_rd_data(ch_rd_data),
    .app_req(app_req), .app_req_addr(app_req_addr), .app_req_len(app_req_len),
    .app_req_wr_n(app_req_wr_n), .app_req_ack(app_req_ack),
    .app_wr_data(app_wr_data), .app_wr_en_n(app_wr_en_n),
    .app_wr_next_req(app_wr_next_req), .app_last_wr(app_last_wr),
    .app_rd_valid(app_rd_valid), .app_last_rd(app_last_rd),
    .app_rd_data(app_rd_data), .arb_err(arb_err)
  );

  typedef struct {int ch; logic [APP_AW-1:0] addr; logic [BL-1:0] len; logic wr_n;} gexp_t;
  typedef struct {logic [NUM_CH-1:0] mask; logic [DW-1:0] data; logic [BEW-1:0] en_n;} wexp_t;
  typedef struct {logic [NUM_CH-1:0] mask; logic [NUM_CH-1:0] last; logic [DW-1:0] data;} rexp_t;

  gexp_t q_g[$];
  wexp_t q_w[$];
  rexp_t q_r[$];
  gexp_t ge;
  wexp_t we;
  rexp_t re;
  int checks = 0;
  int fails  = 0;

  logic              auto_ack, keep_req;
  int                ack_dly, ack_cnt;
  logic [NUM_CH-1:0] acked;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: pops an expectation whenever the DUT side shows activity.
  always @(negedge wb_clk_i) begin
    if (!wb_rst_i) begin
      if (app_req && app_req_ack) begin
        if (q_g.size() == 0) chk("grant_unexpected", 64'(ch_req_ack), 64'(0));
        else begin
          ge = q_g.pop_front();
          chk("grant_ack", 64'(ch_req_ack), 64'(1) << ge.ch);
          chk("grant_addr", 64'(app_req_addr), 64'(ge.addr));
          chk("grant_len", 64'(app_req_len), 64'(ge.len));
          chk("grant_wr_n", 64'(app_req_wr_n), 64'(ge.wr_n));
        end
      end else if (ch_req_ack != '0) chk("stray_ack", 64'(ch_req_ack), 64'(0));
      if (app_wr_next_req || ch_wr_next != '0) begin
        if (q_w.size() == 0) chk("wbeat_unexpected", 64'(ch_wr_next), 64'(0));
        else begin
          we = q_w.pop_front();
          chk("wr_next", 64'(ch_wr_next), 64'(we.mask));
          if (we.mask != '0) begin
            chk("wr_data", 64'(app_wr_data), 64'(we.data));
            chk("wr_en_n", 64'(app_wr_en_n), 64'(we.en_n));
          end else chk("wr_en_n_empty", 64'(app_wr_en_n), 64'(4'hF));
        end
      end
      if (app_rd_valid || app_last_rd || ch_rd_valid != '0 || ch_last_rd != '0) begin
        if (q_r.size() == 0) chk("rbeat_unexpected", 64'(ch_rd_valid), 64'(0));
        else begin
          re = q_r.pop_front();
          chk("rd_valid", 64'(ch_rd_valid), 64'(re.mask));
          chk("rd_last", 64'(ch_last_rd), 64'(re.last));
          if (re.mask != '0) chk("rd_data", 64'(ch_rd_data), 64'(re.data));
        end
      end
    end
  end

  // One clock: release acked requestors and run the auto-ack controller model.
  task automatic step();
    @(negedge wb_clk_i);
    acked = ch_req_ack;
    @(posedge wb_clk_i);
    #1;
    if (!keep_req) ch_req = ch_req & ~acked;
    if (app_req_ack) app_req_ack = 1'b0;
    else if (auto_ack && app_req) begin
      if (ack_cnt >= ack_dly) begin
        app_req_ack = 1'b1;
        ack_cnt = 0;
      end else ack_cnt++;
    end
  endtask

  task automatic set_ch(input int ch, input logic wr_n, input logic [APP_AW-1:0] addr,
                        input logic [BL-1:0] len, input logic expect_it);
    ch_req_addr[ch*APP_AW +: APP_AW] = addr;
    ch_req_len[ch*BL +: BL] = len;
    ch_req_wr_n[ch] = wr_n;
    ch_req[ch] = 1'b1;
    if (expect_it) q_g.push_back('{ch: ch, addr: addr, len: len, wr_n: wr_n});
  endtask

  task automatic wait_grants(input int budget, input string name);
    int n;
    n = 0;
    while (q_g.size() != 0 && n < budget) begin
      step();
      n++;
    end
    chk(name, 64'(q_g.size()), 64'(0));
    q_g.delete();
  endtask

  task automatic wbeat(input int ch, input logic [DW-1:0] d, input logic [BEW-1:0] en,
                       input logic last, input logic [NUM_CH-1:0] exp_mask);
    ch_wr_data = {NUM_CH{~d}};
    ch_wr_en_n = {NUM_CH{~en}};
    ch_wr_data[ch*DW +: DW] = d;
    ch_wr_en_n[ch*BEW +: BEW] = en;
    app_wr_next_req = 1'b1;
    app_last_wr = last;
    q_w.push_back('{mask: exp_mask, data: d, en_n: en});
    step();
    app_wr_next_req = 1'b0;
    app_last_wr = 1'b0;
  endtask

  task automatic rbeat(input logic [NUM_CH-1:0] exp_mask, input logic [DW-1:0] d, input logic last);
    app_rd_valid = 1'b1;
    app_last_rd = last;
    app_rd_data = d;
    q_r.push_back('{mask: exp_mask, last: last ? exp_mask : '0, data: d});
    step();
    app_rd_valid = 1'b0;
    app_last_rd = 1'b0;
  endtask

  task automatic do_reset();
    wb_rst_i = 1'b1;
    ch_req = '0; ch_req_addr = '0; ch_req_len = '0; ch_req_wr_n = '1;
    ch_wr_data = '0; ch_wr_en_n = '1; app_req_ack = 1'b0;
    app_wr_next_req = 1'b0; app_last_wr = 1'b0; app_rd_valid = 1'b0;
    app_last_rd = 1'b0; app_rd_data = '0;
    auto_ack = 1'b1; keep_req = 1'b0; ack_dly = 2; ack_cnt = 0;
    step();
    step();
  endtask

  task automatic end_reset();
    wb_rst_i = 1'b0;
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset values
    do_reset();
    chk("rst_app_req", 64'(app_req), 64'(0));
    chk("rst_addr", 64'(app_req_addr), 64'(0));
    chk("rst_len", 64'(app_req_len), 64'(0));
    chk("rst_wr_n", 64'(app_req_wr_n), 64'(1));
    chk("rst_ack", 64'(ch_req_ack), 64'(0));
    chk("rst_strobes", 64'({ch_wr_next, ch_rd_valid, ch_last_rd}), 64'(0));
    chk("rst_err", 64'(arb_err), 64'(0));
    chk("rst_en_n", 64'(app_wr_en_n), 64'(4'hF));
    end_reset();

    // Four simultaneous reads: round-robin from 0
    for (int c = 0; c < NUM_CH; c++)
      set_ch(c, 1'b1, APP_AW'(26'h100 + c * 26'h40), BL'(c + 1), 1'b1);
    wait_grants(80, "t1_grants_done");
    for (int c = 0; c < NUM_CH; c++) rbeat(NUM_CH'(1) << c, 32'hA000_0000 + c, 1'b1);

    // ch1 write len 4, ch2 read len 2, data phases routed to owners
    do_reset();
    end_reset();
    set_ch(1, 1'b0, 26'h2000, 9'd4, 1'b1);
    wait_grants(30, "t2_wr_grant");
    set_ch(2, 1'b1, 26'h3000, 9'd2, 1'b1);
    wait_grants(30, "t2_rd_grant");
    for (int k = 0; k < 4; k++)
      wbeat(1, 32'hC0DE_0000 + k, BEW'(k), k == 3, 4'b0010);
    chk("t2_en_idle", 64'(app_wr_en_n), 64'(4'hF));
    rbeat(4'b0100, 32'h1234_5678, 1'b0);
    rbeat(4'b0100, 32'h9ABC_DEF0, 1'b1);

    // Read tag FIFO full: fifth read stalls, write still granted
    do_reset();
    end_reset();
    for (int c = 0; c < 3; c++) set_ch(c, 1'b1, APP_AW'(26'h500 + c), 9'd1, 1'b1);
    wait_grants(60, "t3_first3");
    set_ch(0, 1'b1, 26'h600, 9'd1, 1'b1);
    wait_grants(30, "t3_fourth");
    set_ch(1, 1'b1, 26'h700, 9'd3, 1'b0);
    set_ch(3, 1'b0, 26'h800, 9'd5, 1'b1);
    wait_grants(30, "t3_wr_granted");
    repeat (6) step();
    chk("t3_no_rd_req", 64'(app_req), 64'(0));
    q_g.push_back('{ch: 1, addr: 26'h700, len: 9'd3, wr_n: 1'b1});
    rbeat(4'b0001, 32'h5555_AAAA, 1'b1);
    wait_grants(30, "t3_rd_after_pop");

    // Protocol errors are sticky and strobes are dropped
    do_reset();
    end_reset();
    rbeat(4'b0000, 32'hDEAD_BEEF, 1'b0);
    chk("t4_err_set", 64'(arb_err), 64'(1));
    wbeat(0, 32'h0BAD_0BAD, 4'h0, 1'b1, 4'b0000);
    repeat (5) step();
    chk("t4_err_sticky", 64'(arb_err), 64'(1));
    do_reset();
    chk("t4_err_cleared", 64'(arb_err), 64'(0));
    end_reset();
    auto_ack = 1'b0;
    app_req_ack = 1'b1;
    step();
    step();
    chk("t4_idle_ack_err", 64'(arb_err), 64'(1));

    // Asynchronous reset in REQ with two tags outstanding
    do_reset();
    end_reset();
    set_ch(1, 1'b1, 26'h0A1, 9'd2, 1'b1);
    set_ch(2, 1'b1, 26'h0A2, 9'd2, 1'b1);
    wait_grants(60, "t5_two_tags");
    auto_ack = 1'b0;
    set_ch(3, 1'b1, 26'h0A3, 9'd2, 1'b0);
    repeat (3) step();
    chk("t5_req_held", 64'(app_req), 64'(1));
    #2;
    wb_rst_i = 1'b1;
    #1;
    chk("t5_async_req", 64'(app_req), 64'(0));
    ch_req = '0;
    step();
    auto_ack = 1'b1;
    end_reset();
    rbeat(4'b0000, 32'h0000_0001, 1'b1);
    wbeat(1, 32'h0000_0002, 4'h0, 1'b1, 4'b0000);
    chk("t5_fifos_empty_err", 64'(arb_err), 64'(1));
    set_ch(2, 1'b1, 26'h0B2, 9'd1, 1'b1);
    set_ch(3, 1'b1, 26'h0B3, 9'd1, 1'b1);
    wait_grants(60, "t5_rr_from_zero");

    // ch0 and ch2 requesting continuously
    do_reset();
    end_reset();
    keep_req = 1'b1;
`ifdef SDR_ARB_PRIO_EN
    for (int n = 0; n < 4; n++) q_g.push_back('{ch: 0, addr: 26'hC0, len: 9'd1, wr_n: 1'b1});
`else
    for (int n = 0; n < 4; n++)
      q_g.push_back('{ch: (n % 2) * 2, addr: (n % 2) ? 26'hC2 : 26'hC0, len: 9'd1, wr_n: 1'b1});
`endif
    set_ch(0, 1'b1, 26'hC0, 9'd1, 1'b0);
    set_ch(2, 1'b1, 26'hC2, 9'd1, 1'b0);
    wait_grants(100, "t6_grants_done");
    repeat (4) step();
    keep_req = 1'b0;
    ch_req = '0;
    step();

    chk("end_wbeats_drained", 64'(q_w.size()), 64'(0));
    chk("end_rbeats_drained", 64'(q_r.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
